// File: rtl/mmu_arb_pkg.sv
// Shared types and constants for the MMU bus arbiter.
package mmu_arb_pkg;

    // Width of the per-requester starvation counters.
    localparam int unsigned STARVE_W = 4;

    // Owner of the read response that is currently in flight. It doubles as the
    // encoding of which requester holds the bus in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_X    = 2'd3
    } owner_t;

    // Arbitration mode: normal priority or an X burst that holds the bus.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_XBURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter. It counts consecutive cycles in which the requester
// asked for the bus and was refused. It promotes the requester once the count
// reaches LIMIT.
module arb_starve_counter
    import mmu_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic promote
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Next count: clear when idle or served, otherwise count up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_C) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign promote = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Arbiter that shares the single-port MMU bus between instruction fetch (I),
// data load/store (D) and the display DMA reader (X). It grants one access per
// cycle and returns the 1-cycle-latency read data to the requester that owns it.
// Starvation counters on I and X let those requesters overtake D. A locked X
// burst holds the bus until its last beat.
module mmu_bus_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_strb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    input  logic                x_req,
    input  logic                x_lock,
    input  logic [ADDR_W-1:0]   x_addr,
    output logic                x_gnt,
    output logic                x_rvalid,
    output logic [DATA_W-1:0]   x_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_wr_ena,
    output logic [DATA_W/8-1:0] mem_wr_strb,
    input  logic [DATA_W-1:0]   mem_rd_data
);

    arb_state_t state_q;
    arb_state_t state_d;
    owner_t     owner_q;
    owner_t     owner_d;
    owner_t     sel;

    logic       i_promote;
    logic       x_promote;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_cnt_i (
        .clk     (clk),
        .rst     (rst),
        .req     (i_req),
        .gnt     (i_gnt),
        .promote (i_promote)
    );

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_cnt_x (
        .clk     (clk),
        .rst     (rst),
        .req     (x_req),
        .gnt     (x_gnt),
        .promote (x_promote)
    );

    // Pick this cycle's bus owner. The order is: burst X, then starved I, then
    // starved X, then D, I, X. Nothing is granted while reset is held.
    always_comb begin
        sel = OWN_NONE;
        if (!rst) begin
            if (state_q == ARB_XBURST && x_req) begin
                sel = OWN_X;
            end else if (i_promote && i_req) begin
                sel = OWN_I;
            end else if (x_promote && x_req) begin
                sel = OWN_X;
            end else if (d_req) begin
                sel = OWN_D;
            end else if (i_req) begin
                sel = OWN_I;
            end else if (x_req) begin
                sel = OWN_X;
            end
        end
    end

    assign i_gnt = (sel == OWN_I);
    assign d_gnt = (sel == OWN_D);
    assign x_gnt = (sel == OWN_X);

    // Steer the memory bus from the granted requester. Only D can write. A D
    // read drives no strobes, and a D write with no strobes raises no write
    // enable.
    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        mem_wr_strb = '0;
        unique case (sel)
            OWN_I: mem_addr = i_addr;
            OWN_X: mem_addr = x_addr;
            OWN_D: begin
                mem_addr    = d_addr;
                mem_wr_data = d_wdata;
                mem_wr_ena  = d_we && (d_strb != '0);
                mem_wr_strb = d_we ? d_strb : '0;
            end
            default: ;
        endcase
    end

    // Burst mode tracking. A granted X beat with lock set keeps or enters the
    // burst. An unlocked granted beat, or X dropping its request, ends it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (x_gnt && x_lock) begin
                    state_d = ARB_XBURST;
                end
            end
            ARB_XBURST: begin
                if (!x_req || (x_gnt && !x_lock)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Tag the response owner for the next cycle. Writes return nothing.
    always_comb begin
        owner_d = OWN_NONE;
        unique case (sel)
            OWN_I:   owner_d = OWN_I;
            OWN_X:   owner_d = OWN_X;
            OWN_D:   owner_d = d_we ? OWN_NONE : OWN_D;
            default: owner_d = OWN_NONE;
        endcase
    end

    // Arbitration state and response-owner registers. Reset drops any
    // in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Return read data to the requester that owns it. All other requesters
    // see zero.
    always_comb begin
        i_rvalid = (owner_q == OWN_I);
        d_rvalid = (owner_q == OWN_D);
        x_rvalid = (owner_q == OWN_X);
        i_rdata  = i_rvalid ? mem_rd_data : '0;
        d_rdata  = d_rvalid ? mem_rd_data : '0;
        x_rdata  = x_rvalid ? mem_rd_data : '0;
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Self-checking bench for mmu_bus_arbiter: directed scenarios and then random
// traffic. Grants and bus outputs are compared to a reference model every cycle.
// Read responses pass through a scoreboard queue to a separate monitor.
module tb_mmu_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, x_req = 1'b0, x_lock = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, x_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rd_data = '0;
    logic [3:0]    d_strb = '0;
    logic          i_gnt, d_gnt, x_gnt, i_rvalid, d_rvalid, x_rvalid, mem_wr_ena;
    logic [DW-1:0] i_rdata, d_rdata, x_rdata, mem_wr_data;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wr_strb;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk (clk), .rst (rst),
        .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt), .i_rvalid (i_rvalid), .i_rdata (i_rdata),
        .d_req (d_req), .d_we (d_we), .d_strb (d_strb), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .x_req (x_req), .x_lock (x_lock), .x_addr (x_addr), .x_gnt (x_gnt),
        .x_rvalid (x_rvalid), .x_rdata (x_rdata),
        .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_wr_ena (mem_wr_ena),
        .mem_wr_strb (mem_wr_strb), .mem_rd_data (mem_rd_data)
    );

    // Requester ids used by the model: 0 none, 1 I, 2 D, 3 X.
    typedef struct {
        int          who;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          m_ci = 0;
    int          m_cx = 0;
    bit          m_burst = 0;
    logic [31:0] pend_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen by the arbiter: one fixed word plus a scramble.
    function automatic logic [31:0] memfn(logic [31:0] a);
        if (a == 32'h10) return 32'h0051_3093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference choice of bus owner. A burst holds the bus while X requests.
    // Otherwise a starved I comes first, then a starved X, then D > I > X.
    function automatic int pick();
        if (m_burst && x_req) return 3;
        if (i_req && m_ci >= LIM) return 1;
        if (x_req && m_cx >= LIM) return 3;
        if (d_req) return 2;
        if (i_req) return 1;
        if (x_req) return 3;
        return 0;
    endfunction

    // Run one clock cycle with the inputs as already set. Check grants and the
    // bus, queue the expected read response, then advance the model.
    task automatic cycle(output int g);
        logic [31:0] ea, ewd;
        logic        ewe;
        logic [3:0]  est;
        @(negedge clk);
        #1;
        g   = pick();
        ea  = (g == 1) ? i_addr : (g == 2) ? d_addr : (g == 3) ? x_addr : 32'h0;
        ewd = (g == 2) ? d_wdata : 32'h0;
        ewe = (g == 2) && d_we && (d_strb != 4'h0);
        est = (g == 2 && d_we) ? d_strb : 4'h0;
        chk("grant", {i_gnt, d_gnt, x_gnt}, {g == 1, g == 2, g == 3});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wr_data", mem_wr_data, ewd);
        chk("mem_wr", {mem_wr_ena, mem_wr_strb}, {ewe, est});
        pend_rd = memfn(mem_addr);
        if (g == 1 || g == 3 || (g == 2 && !d_we)) sbq.push_back('{g, memfn(ea), cyc + 1});
        m_ci    = (i_req && g != 1) ? ((m_ci + 1 > LIM) ? LIM : m_ci + 1) : 0;
        m_cx    = (x_req && g != 3) ? ((m_cx + 1 > LIM) ? LIM : m_cx + 1) : 0;
        m_burst = (g == 3) && x_lock;
        @(posedge clk);
        #1 mem_rd_data = pend_rd;
    endtask

    // Pulse reset between clock edges while requests are still active.
    task automatic reset_mid();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("gnt_in_rst", {i_gnt, d_gnt, x_gnt}, 3'b000);
        chk("rvalid_in_rst", {i_rvalid, d_rvalid, x_rvalid}, 3'b000);
        chk("addr_in_rst", mem_addr, 32'h0);
        sbq.delete();
        m_ci    = 0;
        m_cx    = 0;
        m_burst = 0;
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Response monitor. Whenever an rvalid appears or a response falls due,
    // pop the scoreboard and compare the owner, the timing and all rdata.
    initial begin
        exp_t       e;
        logic [2:0] v;
        forever begin
            @(posedge clk);
            #2;
            v = {i_rvalid, d_rvalid, x_rvalid};
            if (v != 3'b000 || (sbq.size() > 0 && sbq[0].due <= cyc)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", v, 3'b000);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid", v, {e.who == 1, e.who == 2, e.who == 3});
                    chk("rvalid_cycle", cyc, e.due);
                    chk("rdata", {i_rdata, d_rdata, x_rdata},
                        {(e.who == 1) ? e.data : 32'h0, (e.who == 2) ? e.data : 32'h0,
                         (e.who == 3) ? e.data : 32'h0});
                end
            end else begin
                chk("idle_rdata", {i_rdata, d_rdata, x_rdata}, 96'h0);
            end
        end
    end

    initial begin
        int g, waited, beats, first, last, n;
        // Reset state, with requests present while reset is high.
        i_req = 1'b1; d_req = 1'b1; x_req = 1'b1;
        #12;
        chk("rst_gnt", {i_gnt, d_gnt, x_gnt}, 3'b000);
        chk("rst_rvalid", {i_rvalid, d_rvalid, x_rvalid}, 3'b000);
        chk("rst_bus", {mem_addr, mem_wr_ena, mem_wr_strb}, 37'h0);
        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        #11 rst = 1'b0;
        cycle(g);

        // Single fetch.
        i_req = 1'b1; i_addr = 32'h10;
        cycle(g);
        i_req = 1'b0;
        cycle(g);

        // D and I together: D first, then I.
        d_req = 1'b1; i_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; i_addr = 32'h80;
        cycle(g);
        d_req = 1'b0;
        cycle(g);
        i_req = 1'b0;
        cycle(g);

        // Store with partial strobes, then a store with no strobes.
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        cycle(g);
        d_strb = 4'b0000;
        cycle(g);
        d_req = 1'b0; d_we = 1'b0;
        cycle(g);

        // Starvation of X behind a continuous D stream.
        d_req = 1'b1; x_req = 1'b1; x_lock = 1'b0; x_addr = 32'h2000; waited = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(g);
            if (g == 3) break;
            waited++;
        end
        chk("starve_wait", waited, LIM);
        x_req = 1'b0;
        cycle(g);

        // Locked four-beat burst with D held throughout.
        x_req = 1'b1; beats = 0; first = -1; last = -1; n = 0;
        while (beats < 4 && n < 30) begin
            x_lock = (beats < 3);
            x_addr = 32'h3000 + 32'(beats * 4);
            cycle(g);
            if (g == 3) begin
                if (first < 0) first = n;
                last = n;
                beats++;
            end
            n++;
        end
        chk("burst_beats", beats, 4);
        chk("burst_consecutive", last - first + 1, 4);
        cycle(g);
        chk("post_burst_d", g, 2);
        x_req = 1'b0; d_req = 1'b0;
        cycle(g);

        // Asynchronous reset in the middle of a burst with a read in flight.
        x_req = 1'b1; x_lock = 1'b1; x_addr = 32'h4000;
        cycle(g);
        cycle(g);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        reset_mid();
        cycle(g);
        chk("post_rst_base", g, 2);
        d_req = 1'b0; x_req = 1'b0; x_lock = 1'b0;
        cycle(g);

        // Random traffic. A request stays up until granted, with an occasional drop.
        g = 0;
        for (int k = 0; k < 1500; k++) begin
            if (!i_req || g == 1 || $urandom_range(0, 9) == 0) begin
                i_req  = $urandom_range(0, 1);
                i_addr = $urandom;
            end
            if (!d_req || g == 2 || $urandom_range(0, 9) == 0) begin
                d_req   = $urandom_range(0, 1);
                d_we    = $urandom_range(0, 1);
                d_strb  = 4'($urandom_range(0, 15));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (!x_req || g == 3 || $urandom_range(0, 9) == 0) begin
                x_req  = ($urandom_range(0, 9) < 4);
                x_lock = ($urandom_range(0, 9) < 7);
                x_addr = $urandom;
            end
            if (k == 700) reset_mid();
            cycle(g);
        end

        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        cycle(g);
        cycle(g);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
